// File: rtl/ps2_menu_keys_if.sv
// PS/2 keyboard lines in, menu key pulses and frame error out.
// The keyboard side drives the master modport and the decoder uses the slave modport.
interface ps2_menu_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyboard_out;
  logic       frame_error;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keyboard_out,
    input  frame_error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keyboard_out,
    output frame_error
  );
endinterface

// File: rtl/ps2_menu_keys.sv
// PS/2 keyboard front end: conditions the lines, receives 11-bit frames, decodes
// E0/F0 scan-code sequences and emits one pulse per press of UP/DOWN/ENTER/ESC.
module ps2_menu_keys #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst,
  ps2_menu_keys_if.slave bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_t;

  // Odd parity over data plus parity bit: set bit count must be odd.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ((^data) ^ par) == 1'b1;
  endfunction

  // shift holds {parity, D7..D0, start} once the stop bit arrives.
  function automatic logic frame_ok(input logic [9:0] shift, input logic stop);
    return (shift[0] == 1'b0) && odd_parity_ok(shift[8:1], shift[9]) && (stop == 1'b1);
  endfunction

  // Returns {hit, index}; index matches the keyboard_out bit position.
  function automatic logic [2:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [2:0] res;
    case ({ext, code})
      9'h175:  res = 3'b100;
      9'h172:  res = 3'b101;
      9'h05A:  res = 3'b110;
      9'h076:  res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  logic           clk_meta_r, clk_sync_r;
  logic           data_meta_r, data_sync_r;
  logic           filt_clk_r;
  logic [FCW-1:0] filt_cnt_r;
  logic           flip_s, strobe_s;
  logic [3:0]     bit_cnt_r;
  logic [9:0]     shift_r;
  logic [TCW-1:0] idle_cnt_r;
  logic [7:0]     byte_r;
  logic           byte_valid_r, frame_error_r;
  state_t         state_r, state_next_s;
  logic           make_s, brk_s, ext_s;
  logic [2:0]     key_s;
  logic [3:0]     pressed_r;
  logic [3:0]     keyboard_out_r;

  // Two-stage synchronisers for both PS/2 lines, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= bus.ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= bus.ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Filter flips on the FILTER_LEN-th consecutive differing sample; a 1->0 flip is a strobe.
  always_comb begin
    flip_s   = (clk_sync_r != filt_clk_r) && (filt_cnt_r == FCW'(FILTER_LEN - 1));
    strobe_s = flip_s && filt_clk_r;
  end

  // Glitch filter on the synchronised PS/2 clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk_r <= 1'b1;
      filt_cnt_r <= '0;
    end else if (clk_sync_r == filt_clk_r) begin
      filt_cnt_r <= '0;
    end else if (flip_s) begin
      filt_clk_r <= clk_sync_r;
      filt_cnt_r <= '0;
    end else begin
      filt_cnt_r <= filt_cnt_r + FCW'(1);
    end
  end

  // Frame receiver: shifts bits in LSB first, checks at the stop bit, clears a stalled frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r     <= 4'd0;
      shift_r       <= 10'd0;
      idle_cnt_r    <= '0;
      byte_r        <= 8'd0;
      byte_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      byte_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      if (strobe_s) begin
        idle_cnt_r <= '0;
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
          byte_r    <= shift_r[8:1];
          if (frame_ok(shift_r, data_sync_r)) begin
            byte_valid_r <= 1'b1;
          end else begin
            frame_error_r <= 1'b1;
          end
        end else begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
          shift_r   <= {data_sync_r, shift_r[9:1]};
        end
      end else if (bit_cnt_r != 4'd0) begin
        if (idle_cnt_r == TCW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_r  <= 4'd0;
          idle_cnt_r <= '0;
        end else begin
          idle_cnt_r <= idle_cnt_r + TCW'(1);
        end
      end else begin
        idle_cnt_r <= '0;
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Decoder next state: a framing error abandons any pending prefix.
  always_comb begin
    state_next_s = state_r;
    if (frame_error_r) begin
      state_next_s = ST_IDLE;
    end else if (byte_valid_r) begin
      case (state_r)
        ST_IDLE: begin
          if (byte_r == 8'hE0) begin
            state_next_s = ST_EXT;
          end else if (byte_r == 8'hF0) begin
            state_next_s = ST_BRK;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (byte_r == 8'hF0) begin
            state_next_s = ST_EXTBRK;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_BRK:    state_next_s = ST_IDLE;
        ST_EXTBRK: state_next_s = ST_IDLE;
        default:   state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Decoder outputs: make/release events for the current byte.
  always_comb begin
    make_s = 1'b0;
    brk_s  = 1'b0;
    ext_s  = 1'b0;
    if (byte_valid_r) begin
      case (state_r)
        ST_IDLE: begin
          make_s = (byte_r != 8'hE0) && (byte_r != 8'hF0);
        end
        ST_EXT: begin
          make_s = (byte_r != 8'hF0);
          ext_s  = 1'b1;
        end
        ST_BRK: begin
          brk_s = 1'b1;
        end
        ST_EXTBRK: begin
          brk_s = 1'b1;
          ext_s = 1'b1;
        end
        default: begin
          make_s = 1'b0;
        end
      endcase
    end else begin
      make_s = 1'b0;
    end
    key_s = key_lookup(byte_r, ext_s);
  end

  // Pressed flags suppress typematic repeats; output pulses only on a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressed_r      <= 4'd0;
      keyboard_out_r <= 4'd0;
    end else begin
      keyboard_out_r <= 4'd0;
      if (make_s && key_s[2] && !pressed_r[key_s[1:0]]) begin
        pressed_r[key_s[1:0]] <= 1'b1;
        keyboard_out_r        <= 4'b0001 << key_s[1:0];
      end else if (brk_s && key_s[2]) begin
        pressed_r[key_s[1:0]] <= 1'b0;
      end else begin
        pressed_r <= pressed_r;
      end
    end
  end

  assign bus.keyboard_out = keyboard_out_r;
  assign bus.frame_error  = frame_error_r;

endmodule
